// File: rtl/mem_bus_pkg.sv
// Shared encodings for the fetch / load-store memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam logic [31:0] GPIO_OUT_ADDR = 32'h10010024;
    localparam logic [31:0] GPIO_IN_ADDR  = 32'h10010028;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin pick; zero latency.
// A tie goes to the requester that did not win last time.
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = if_req | d_req;
        grant_id    = GNT_IF;
        if (if_req && d_req) begin
            grant_id = ~last_grant;
        end else if (d_req) begin
            grant_id = GNT_D;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory/GPIO bus between fetch and load/store; ack MEM_LATENCY+1 cycles after grant.
// Requests wait (no preemption) while a transaction is in ACCESS or RESP.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_we,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t                state_q, state_d;
    logic                  last_q, gnt_q, we_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
    logic                  grant_valid, grant_id;
    logic                  last_cycle;

    rr_arb2 u_rr_arb2 (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign last_cycle = (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ACCESS;
            ACCESS:  if (last_cycle)  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= GNT_D;
            gnt_q      <= GNT_IF;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state_q == IDLE && grant_valid) begin
                last_q  <= grant_id;
                gnt_q   <= grant_id;
                cnt_q   <= CNT_LOAD;
                addr_q  <= (grant_id == GNT_D) ? d_addr : if_addr;
                wdata_q <= (grant_id == GNT_D) ? d_wdata : '0;
                we_q    <= (grant_id == GNT_D) ? d_we : 1'b0;
            end
            if (state_q == ACCESS) begin
                if (!last_cycle) cnt_q <= cnt_q - 1'b1;
                if (last_cycle && !we_q) begin
                    if (gnt_q == GNT_D) d_rdata_q  <= mem_rdata;
                    else                if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // Outputs decode from state_q so an async reset clears them at once.
    always_comb begin
        busy      = (state_q != IDLE);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        if (state_q == ACCESS || state_q == RESP) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        if (state_q == ACCESS && cnt_q == CNT_LOAD) mem_we = we_q;
        if (state_q == RESP) begin
            if_ack = (gnt_q == GNT_IF);
            d_ack  = (gnt_q == GNT_D);
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter at MEM_LATENCY=2, plus a MEM_LATENCY=1 copy.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_we, busy;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_ack1, d_ack1, mem_we1, busy1;

    logic        fixed_mode = 1'b0;
    logic [31:0] rd_val = '0;
    int tests = 0, fails = 0;

    function automatic logic [31:0] hashf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
    endfunction

    assign mem_rdata  = fixed_mode ? rd_val : hashf(mem_addr);
    assign mem_rdata1 = fixed_mode ? rd_val : hashf(mem_addr1);

    always #5 clk = ~clk;

    mem_bus_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(L), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_bus_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ack(if_ack1),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: the first IDLE cycle after reset release.
    task automatic do_reset();
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Requests already raised in the current cycle; waits for the ack of one requester.
    task automatic wait_ack(input bit is_d, output int lat, output int we_cnt,
                            output logic [31:0] we_addr, output logic [31:0] we_data,
                            output bit other_ack);
        lat = 0; we_cnt = 0; we_addr = '0; we_data = '0; other_ack = 1'b0;
        while (!(is_d ? d_ack : if_ack) && lat < 20) begin
            step();
            lat++;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            if (is_d ? if_ack : d_ack) other_ack = 1'b1;
        end
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    task automatic test_reset();
        step();
        reset = 1'b1;
        #1;
        tests++;
        if ({if_ack, d_ack, busy, mem_we} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0000", {if_ack, d_ack, busy, mem_we});
        end
        tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        tests++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: got if=%h d=%h want 0", if_rdata, d_rdata);
        end
    endtask

    task automatic test_fetch();
        int lat, wc; logic [31:0] wa, wd; bit oth;
        do_reset();
        fixed_mode = 1'b1;
        rd_val = 32'h2008000A;
        if_addr = 32'h00400000;
        if_req = 1'b1;
        step();
        tests++;
        if (mem_addr !== 32'h00400000) begin
            fails++;
            $display("FAIL fetch_addr: got %h want 00400000", mem_addr);
        end
        wait_ack(1'b0, lat, wc, wa, wd, oth);
        lat++;
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL fetch_lat: got %0d want 3", lat); end
        tests++;
        if (if_rdata !== 32'h2008000A) begin
            fails++; $display("FAIL fetch_rdata: got %h want 2008000a", if_rdata);
        end
        tests++;
        if (oth || wc != 0) begin
            fails++; $display("FAIL fetch_side: got d_ack=%0d we_cnt=%0d want 0 0", oth, wc);
        end
        step();
        tests++;
        if ({if_ack, busy} !== 2'b00) begin
            fails++; $display("FAIL fetch_pulse: got ack,busy=%b want 00", {if_ack, busy});
        end
    endtask

    task automatic test_store();
        int lat, wc; logic [31:0] wa, wd; bit oth;
        do_reset();
        d_addr = GPIO_OUT_ADDR; d_wdata = 32'h000000FF; d_we = 1'b1; d_req = 1'b1;
        wait_ack(1'b1, lat, wc, wa, wd, oth);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL store_lat: got %0d want 3", lat); end
        tests++;
        if (wc !== 1 || wa !== GPIO_OUT_ADDR || wd !== 32'hFF) begin
            fails++;
            $display("FAIL store_strobe: got cnt=%0d addr=%h data=%h want 1 %h ff", wc, wa, wd, GPIO_OUT_ADDR);
        end
        tests++;
        if (d_rdata !== 32'h0 || oth) begin
            fails++; $display("FAIL store_rdata: got %h if_ack=%0d want 0 0", d_rdata, oth);
        end
        d_we = 1'b0;
    endtask

    task automatic test_both();
        logic [1:0] exp_ack;
        do_reset();
        fixed_mode = 1'b0;
        if_addr = 32'h00400010; d_addr = 32'h10010028; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 18; c++) begin
            exp_ack = (c == 3 || c == 11) ? 2'b10 : (c == 7 || c == 15) ? 2'b01 : 2'b00;
            tests++;
            if ({if_ack, d_ack} !== exp_ack) begin
                fails++; $display("FAIL both_ack c=%0d: got %b want %b", c, {if_ack, d_ack}, exp_ack);
            end
            tests++;
            if (busy !== (c % 4 != 0)) begin
                fails++; $display("FAIL both_busy c=%0d: got %b want %b", c, busy, (c % 4 != 0));
            end
            if (exp_ack == 2'b10) begin
                tests++;
                if (if_rdata !== hashf(if_addr)) begin
                    fails++; $display("FAIL both_ifdata: got %h want %h", if_rdata, hashf(if_addr));
                end
            end
            if (exp_ack == 2'b01) begin
                tests++;
                if (d_rdata !== hashf(d_addr)) begin
                    fails++; $display("FAIL both_ddata: got %h want %h", d_rdata, hashf(d_addr));
                end
            end
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_load_then_fetch();
        logic [1:0] exp_ack;
        do_reset();
        fixed_mode = 1'b1; rd_val = 32'h5;
        d_addr = GPIO_IN_ADDR; d_we = 1'b0; d_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) begin
                if_addr = 32'h00400004; if_req = 1'b1;
                tests++;
                if (mem_addr !== GPIO_IN_ADDR) begin
                    fails++; $display("FAIL lf_addr: got %h want %h", mem_addr, GPIO_IN_ADDR);
                end
            end
            exp_ack = (c == 3) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
            tests++;
            if ({if_ack, d_ack} !== exp_ack) begin
                fails++; $display("FAIL lf_ack c=%0d: got %b want %b", c, {if_ack, d_ack}, exp_ack);
            end
            if (c == 3) begin
                tests++;
                if (d_rdata !== 32'h5) begin fails++; $display("FAIL lf_drdata: got %h want 5", d_rdata); end
                d_req = 1'b0;
                rd_val = 32'h11112222;
            end
            if (c == 7) begin
                tests++;
                if (if_rdata !== 32'h11112222) begin
                    fails++; $display("FAIL lf_ifrdata: got %h want 11112222", if_rdata);
                end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, wc; logic [31:0] wa, wd; bit oth, seen;
        do_reset();
        d_addr = GPIO_OUT_ADDR; d_wdata = 32'hA5; d_we = 1'b1; d_req = 1'b1;
        step();
        tests++;
        if (mem_we !== 1'b1) begin fails++; $display("FAIL rm_pre: got mem_we=%b want 1", mem_we); end
        reset = 1'b1;
        #1;
        tests++;
        if ({mem_we, busy, d_ack} !== 3'b000) begin
            fails++; $display("FAIL rm_async: got we,busy,ack=%b want 000", {mem_we, busy, d_ack});
        end
        d_req = 1'b0;
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (d_ack || busy) seen = 1'b1;
        end
        tests++;
        if (seen) begin fails++; $display("FAIL rm_drop: got stray ack/busy want none"); end
        d_req = 1'b1;
        wait_ack(1'b1, lat, wc, wa, wd, oth);
        tests++;
        if (lat !== 3 || wc !== 1 || wd !== 32'hA5) begin
            fails++; $display("FAIL rm_reissue: got lat=%0d we=%0d data=%h want 3 1 a5", lat, wc, wd);
        end
        d_we = 1'b0;
    endtask

    task automatic test_lat1();
        int lat, wc;
        do_reset();
        fixed_mode = 1'b1; rd_val = 32'hCAFEF00D;
        if_addr = 32'h00400008; if_req = 1'b1;
        lat = 0; wc = 0;
        while (!if_ack1 && lat < 20) begin
            step();
            lat++;
            if (mem_we1) wc++;
        end
        if_req = 1'b0;
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL l1_lat: got %0d want 2", lat); end
        tests++;
        if (if_rdata1 !== 32'hCAFEF00D || wc != 0) begin
            fails++; $display("FAIL l1_rdata: got %h we=%0d want cafef00d 0", if_rdata1, wc);
        end
    endtask

    // Model: bus is free from cycle free_at; a grant at c acks at c+L+1 and frees at c+L+2.
    task automatic test_random();
        int free_at = 0, exp_cyc = -1, grant_cyc = -10;
        logic last = GNT_D, exp_id = GNT_IF, g_we = 1'b0;
        logic [31:0] g_addr = '0, g_wdata = '0, mdl_if = '0, mdl_d = '0;
        bit just_if, just_d, e_if, e_d, e_we;
        do_reset();
        fixed_mode = 1'b0;
        for (int c = 0; c < 400; c++) begin
            just_if = 1'b0; just_d = 1'b0;
            e_if = (c == exp_cyc) && (exp_id == GNT_IF);
            e_d  = (c == exp_cyc) && (exp_id == GNT_D);
            e_we = (c == grant_cyc + 1) && g_we;
            tests++;
            if ({if_ack, d_ack} !== {e_if, e_d}) begin
                fails++; $display("FAIL rnd_ack c=%0d: got %b want %b", c, {if_ack, d_ack}, {e_if, e_d});
            end
            tests++;
            if (mem_we !== e_we) begin
                fails++; $display("FAIL rnd_we c=%0d: got %b want %b", c, mem_we, e_we);
            end
            if (e_we) begin
                tests++;
                if (mem_addr !== g_addr || mem_wdata !== g_wdata) begin
                    fails++;
                    $display("FAIL rnd_wbus c=%0d: got %h/%h want %h/%h", c, mem_addr, mem_wdata, g_addr, g_wdata);
                end
            end
            if (e_if) begin
                tests++;
                if (if_rdata !== mdl_if) begin
                    fails++; $display("FAIL rnd_ifdata c=%0d: got %h want %h", c, if_rdata, mdl_if);
                end
                if_req = 1'b0; just_if = 1'b1;
            end
            if (e_d) begin
                tests++;
                if (d_rdata !== mdl_d) begin
                    fails++; $display("FAIL rnd_ddata c=%0d: got %h want %h", c, d_rdata, mdl_d);
                end
                d_req = 1'b0; just_d = 1'b1;
            end
            if (!if_req && !just_if && $urandom_range(2) == 0) begin
                if_addr = $urandom; if_req = 1'b1;
            end
            if (!d_req && !just_d && $urandom_range(2) == 0) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(1) == 1; d_req = 1'b1;
            end
            if (c >= free_at && (if_req || d_req)) begin
                exp_id = (if_req && d_req) ? ~last : (d_req ? GNT_D : GNT_IF);
                last = exp_id;
                grant_cyc = c;
                exp_cyc = c + L + 1;
                free_at = c + L + 2;
                g_we    = (exp_id == GNT_D) ? d_we : 1'b0;
                g_addr  = (exp_id == GNT_D) ? d_addr : if_addr;
                g_wdata = d_wdata;
                if (exp_id == GNT_IF) mdl_if = hashf(if_addr);
                else if (!d_we)       mdl_d  = hashf(d_addr);
            end
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_both();
        test_load_then_fetch();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
